sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Parametrised NCH-channel arbiter joining pipeline-side SRAM-like masters onto one SRAM-like slave port. Default NCH=2: channel 0 = IF stage fetch, channel 1 = EXE/MEM data access.
- Supports several outstanding transactions, up to MAX_OUT.
- An in-order ID FIFO records which master issued each accepted request and returns that request's data_ok/rdata to it.
- Sits between the CPU stages and the cache/AXI bridge, replacing the fixed inst/data SRAM ports.

Parameters:
- NCH, 2, number of master channels (2..8).
- AW, 32, address width.
- DW, 32, data width.
- MAX_OUT, 4, maximum accepted-but-not-completed transactions (1..16).
- PRIO_MODE, 0, arbitration policy. 0 = fixed priority, highest index wins. 1 = round-robin.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- m_req  in  NCH  per-master request, held until accepted.
- m_wr  in  NCH  per-master write flag.
- m_size  in  2*NCH  per-master size: 0=byte, 1=half, 2=word.
- m_addr  in  AW*NCH  per-master address.
- m_wdata  in  DW*NCH  per-master write data.
- m_addr_ok  out  NCH  request accepted, one-hot or zero.
- m_data_ok  out  NCH  transaction complete, one-hot or zero.
- m_rdata  out  DW  read data, broadcast to all masters.
- s_req  out  1  slave request.
- s_wr  out  1  slave write flag.
- s_size  out  2  slave size.
- s_addr  out  AW  slave address.
- s_wdata  out  DW  slave write data.
- s_addr_ok  in  1  slave accepted the request.
- s_data_ok  in  1  slave completed the oldest transaction.
- s_rdata  in  DW  slave read data.
- outstanding  out  clog2(MAX_OUT+1)  current count of in-flight transactions.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (resetn low, asynchronous):
  - ID FIFO pointers and count cleared to 0; lock cleared; round-robin pointer set to 0; proto_err cleared.
  - All outputs 0 during reset: s_req=0, m_addr_ok=0, m_data_ok=0, outstanding=0.
  - Transactions in flight at reset are discarded; no data_ok is ever produced for them.
- full = (count==MAX_OUT); empty = (count==0).
- Grant selection:
  - When unlocked, the grant is chosen combinationally from m_req per PRIO_MODE.
  - Round-robin: search starts at rr_ptr. On every accept, rr_ptr <= granted+1 mod NCH.
- Request path:
  - s_req = |m_req & ~full & resetn.
  - s_wr, s_size, s_addr and s_wdata are multiplexed from the granted master.
- Lock:
  - If s_req=1 and s_addr_ok=0, the lock register captures the grant. The grant is frozen while locked, even if a higher-priority master raises m_req.
  - Lock clears on the accept cycle.
  - Guarantee: the slave never sees s_addr/s_wr change while s_req is held.
- Accept (s_req & s_addr_ok):
  - m_addr_ok[grant]=1 in the same cycle.
  - The grant ID is pushed into the FIFO at the clock edge; count increments.
- Completion (s_data_ok & ~empty):
  - m_data_ok[head]=1 in the same cycle; m_rdata = s_rdata (combinational pass-through).
  - Head is popped at the edge. Writes complete through data_ok exactly like reads.
- Simultaneous accept and completion: push and pop in the same edge; count is unchanged.
- Full: s_req is forced low, including in a cycle where a pop also occurs. Acceptance resumes the following cycle.
  - Consequence: with MAX_OUT=1, back-to-back throughput is one transaction every 2 cycles minimum.
- A request cannot complete in its own accept cycle. s_data_ok on an empty FIFO (count==0 at the start of the cycle) is ignored, sets proto_err=1 (sticky until reset), and gives m_data_ok=0.
- Pointers wrap modulo MAX_OUT; MAX_OUT need not be a power of two.
- outstanding = count, registered.
- At most one m_addr_ok bit and one m_data_ok bit are high per cycle.

Test Plan:
- NCH=2, PRIO_MODE=0:
  - m_req=2'b11, s_addr_ok=1 every cycle → ch1 accepted every cycle until full at 4 outstanding, then s_req=0.
  - s_data_ok pulses return m_data_ok=2'b10 four times; outstanding goes 4→0.
- Lock: ch0 requests addr 0x1FC00000 with s_addr_ok=0 for 3 cycles while ch1 raises m_req in cycle 2 → s_addr stays 0x1FC00000 all 3 cycles. Assert s_addr_ok → m_addr_ok=2'b01; ch1 is granted the next cycle.
- Ordering: accept ch0 read, ch1 write, ch0 read; return three s_data_ok with rdata 0xA,0xB,0xC → m_data_ok sequence 01,10,01, with m_rdata 0xA and 0xC on the ch0 completions.
- Simultaneous: count=2, accept and s_data_ok in the same cycle → outstanding stays 2; full case MAX_OUT=4, count=4, pop → no accept that cycle, accept next cycle.
- PRIO_MODE=1, NCH=3, all m_req held, s_addr_ok=1 → grant order 0,1,2,0,1,2.
- Error/reset: s_data_ok with outstanding=0 → proto_err=1, m_data_ok=0. resetn low mid-burst (count=3), asynchronously → outstanding=0, proto_err=0, s_req=0 immediately.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: joins NCH SRAM-like masters onto one SRAM-like slave, with in-order data return
module sram_like_arbiter #(
  parameter int NCH = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_OUT = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NCH-1:0]                m_req,
  input  logic [NCH-1:0]                m_wr,
  input  logic [2*NCH-1:0]              m_size,
  input  logic [AW*NCH-1:0]             m_addr,
  input  logic [DW*NCH-1:0]             m_wdata,
  output logic [NCH-1:0]                m_addr_ok,
  output logic [NCH-1:0]                m_data_ok,
  output logic [DW-1:0]                 m_rdata,
  output logic                          s_req,
  output logic                          s_wr,
  output logic [1:0]                    s_size,
  output logic [AW-1:0]                 s_addr,
  output logic [DW-1:0]                 s_wdata,
  input  logic                          s_addr_ok,
  input  logic                          s_data_ok,
  input  logic [DW-1:0]                 s_rdata,
  output logic [$clog2(MAX_OUT+1)-1:0]  outstanding,
  output logic                          proto_err
);
  localparam int IW = $clog2(NCH);
  localparam int PW = MAX_OUT > 1 ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT+1);
  typedef enum logic {UNLOCKED, LOCKED} lock_t;
  lock_t lock_q, lock_d;
  logic [IW-1:0] lock_id_q, sel, grant, rr_ptr, head_id;
  logic [IW-1:0] id_mem [MAX_OUT];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic full, empty, accept, pop;
  // candidate grant: highest index in fixed mode, first requester at or after rr_ptr in round-robin
  always_comb begin
    sel = '0;
    if (PRIO_MODE == 0) begin
      for (int i = 0; i < NCH; i++) if (m_req[IW'(i)]) sel = IW'(i);
    end else begin
      for (int i = NCH-1; i >= 0; i--)
        if (m_req[IW'((int'(rr_ptr) + i) % NCH)]) sel = IW'((int'(rr_ptr) + i) % NCH);
    end
  end
  assign grant = lock_q == LOCKED ? lock_id_q : sel;
  assign full = count == CW'(MAX_OUT);
  assign empty = count == '0;
  assign s_req = |m_req & ~full & resetn;
  assign accept = s_req & s_addr_ok;
  assign pop = s_data_ok & ~empty;
  assign s_wr = m_wr[grant];
  assign s_size = m_size[int'(grant)*2 +: 2];
  assign s_addr = m_addr[int'(grant)*AW +: AW];
  assign s_wdata = m_wdata[int'(grant)*DW +: DW];
  assign head_id = id_mem[head];
  assign m_addr_ok = accept ? NCH'(1) << grant : '0;
  assign m_data_ok = pop ? NCH'(1) << head_id : '0;
  assign m_rdata = s_rdata;
  assign outstanding = count;
  // a stalled request freezes the grant so the slave sees stable address and command
  always_comb begin
    lock_d = accept ? UNLOCKED : s_req ? LOCKED : lock_q;
  end
  // lock state, captured grant and round-robin pointer
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_q <= UNLOCKED;
      lock_id_q <= '0;
      rr_ptr <= '0;
    end else begin
      lock_q <= lock_d;
      if (s_req && !s_addr_ok) lock_id_q <= grant;
      if (accept) rr_ptr <= grant == IW'(NCH-1) ? '0 : grant + 1'b1;
    end
  end
  // ID FIFO pointers, occupancy and sticky error for data_ok with nothing in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      proto_err <= 1'b0;
    end else begin
      if (accept) tail <= tail == PW'(MAX_OUT-1) ? '0 : tail + 1'b1;
      if (pop) head <= head == PW'(MAX_OUT-1) ? '0 : head + 1'b1;
      count <= count + CW'(accept) - CW'(pop);
      proto_err <= proto_err | (s_data_ok & empty);
    end
  end
  // ID storage needs no reset: entries are only read behind a valid count
  always_ff @(posedge clk) begin
    if (accept) id_mem[tail] <= grant;
  end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: scoreboard-checked bench for fixed-priority and round-robin arbiters
module tb_sram_like_arbiter;
  logic clk = 1'b0;
  logic resetn;
  logic [1:0] m_req, m_wr, m_addr_ok, m_data_ok;
  logic [3:0] m_size;
  logic [63:0] m_addr, m_wdata;
  logic [31:0] m_rdata, s_addr, s_wdata, s_rdata;
  logic s_req, s_wr, s_addr_ok, s_data_ok, proto_err;
  logic [1:0] s_size;
  logic [2:0] outstanding;
  logic [2:0] r_req, r_wr, r_addr_ok, r_data_ok;
  logic [5:0] r_size;
  logic [95:0] r_addr, r_wdata;
  logic [31:0] r_rdata, r_s_addr, r_s_wdata, r_s_rdata;
  logic r_s_req, r_s_wr, r_s_addr_ok, r_s_data_ok, r_perr;
  logic [1:0] r_s_size;
  logic [3:0] r_out;
  int checks = 0;
  int errors = 0;
  int cnt = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  sram_like_arbiter #(.NCH(2), .MAX_OUT(4), .PRIO_MODE(0)) dut (
    .clk(clk), .resetn(resetn), .m_req(m_req), .m_wr(m_wr), .m_size(m_size),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .m_rdata(m_rdata), .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outstanding(outstanding), .proto_err(proto_err)
  );

  sram_like_arbiter #(.NCH(3), .MAX_OUT(8), .PRIO_MODE(1)) dut_rr (
    .clk(clk), .resetn(resetn), .m_req(r_req), .m_wr(r_wr), .m_size(r_size),
    .m_addr(r_addr), .m_wdata(r_wdata), .m_addr_ok(r_addr_ok), .m_data_ok(r_data_ok),
    .m_rdata(r_rdata), .s_req(r_s_req), .s_wr(r_s_wr), .s_size(r_s_size), .s_addr(r_s_addr),
    .s_wdata(r_s_wdata), .s_addr_ok(r_s_addr_ok), .s_data_ok(r_s_data_ok), .s_rdata(r_s_rdata),
    .outstanding(r_out), .proto_err(r_perr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input int ch, input logic wr);
    m_req = 2'b01 << ch;
    m_wr = {1'b0, wr} << ch;
    s_addr_ok = 1'b1;
    #2;
    checks++;
    if (m_addr_ok !== 2'b01 << ch) begin
      errors++;
      $display("FAIL accept_addr_ok ch%0d: got %b expected %b", ch, m_addr_ok, 2'b01 << ch);
    end
    checks++;
    if (s_addr !== m_addr[ch*32 +: 32] || s_wr !== wr) begin
      errors++;
      $display("FAIL accept_mux ch%0d: got addr %h wr %b expected addr %h wr %b", ch, s_addr, s_wr, m_addr[ch*32 +: 32], wr);
    end
    exp_q.push_back(ch);
    cnt++;
    step();
    m_req = '0;
    m_wr = '0;
    s_addr_ok = 1'b0;
  endtask

  task automatic drain(input int n, input logic [31:0] base);
    int ch;
    for (int i = 0; i < n; i++) begin
      s_data_ok = 1'b1;
      s_rdata = base + 32'(i);
      #2;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL drain_underflow: got data_ok %b expected no completion pending", m_data_ok);
      end else begin
        ch = exp_q.pop_front();
        if (m_data_ok !== 2'b01 << ch || m_rdata !== base + 32'(i)) begin
          errors++;
          $display("FAIL drain_data_ok: got %b/%h expected %b/%h", m_data_ok, m_rdata, 2'b01 << ch, base + 32'(i));
        end
      end
      step();
      cnt--;
      checks++;
      if (outstanding !== 3'(cnt)) begin
        errors++;
        $display("FAIL drain_outstanding: got %0d expected %0d", outstanding, cnt);
      end
    end
    s_data_ok = 1'b0;
  endtask

  task automatic test_reset();
    m_req = 2'b11;
    s_addr_ok = 1'b1;
    s_data_ok = 1'b1;
    #2;
    checks++;
    if (s_req !== 1'b0 || m_addr_ok !== 2'b00 || m_data_ok !== 2'b00 || outstanding !== 3'd0 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got s_req %b addr_ok %b data_ok %b out %0d perr %b expected all 0", s_req, m_addr_ok, m_data_ok, outstanding, proto_err);
    end
    m_req = '0;
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  task automatic test_fill();
    m_req = 2'b11;
    m_addr = {32'h0000_0200, 32'h0000_0100};
    s_addr_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      checks++;
      if (s_req !== (cnt < 4) || m_addr_ok !== (cnt < 4 ? 2'b10 : 2'b00)) begin
        errors++;
        $display("FAIL fill_cycle%0d: got s_req %b addr_ok %b expected s_req %b addr_ok %b", i, s_req, m_addr_ok, cnt < 4, cnt < 4 ? 2'b10 : 2'b00);
      end
      if (cnt < 4) begin
        exp_q.push_back(1);
        cnt++;
      end
      step();
    end
    m_req = '0;
    s_addr_ok = 1'b0;
    checks++;
    if (outstanding !== 3'd4) begin
      errors++;
      $display("FAIL fill_outstanding: got %0d expected 4", outstanding);
    end
    drain(4, 32'h50);
  endtask

  task automatic test_lock();
    m_addr = {32'h0000_0300, 32'h1FC0_0000};
    m_req = 2'b01;
    s_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) m_req = 2'b11;
      #2;
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h1FC0_0000 || m_addr_ok !== 2'b00) begin
        errors++;
        $display("FAIL lock_hold%0d: got s_req %b addr %h addr_ok %b expected 1 1fc00000 00", i, s_req, s_addr, m_addr_ok);
      end
      step();
    end
    s_addr_ok = 1'b1;
    #2;
    checks++;
    if (m_addr_ok !== 2'b01 || s_addr !== 32'h1FC0_0000) begin
      errors++;
      $display("FAIL lock_accept: got addr_ok %b addr %h expected 01 1fc00000", m_addr_ok, s_addr);
    end
    exp_q.push_back(0);
    cnt++;
    step();
    m_req = 2'b10;
    #2;
    checks++;
    if (m_addr_ok !== 2'b10 || s_addr !== 32'h0000_0300) begin
      errors++;
      $display("FAIL lock_next: got addr_ok %b addr %h expected 10 00000300", m_addr_ok, s_addr);
    end
    exp_q.push_back(1);
    cnt++;
    step();
    m_req = '0;
    s_addr_ok = 1'b0;
    drain(2, 32'h70);
  endtask

  task automatic test_ordering();
    m_addr = {32'h0000_4000, 32'h0000_8000};
    m_wdata = {32'hDEAD_BEEF, 32'h0};
    do_accept(0, 1'b0);
    m_req = 2'b10;
    m_wr = 2'b10;
    #2;
    checks++;
    if (s_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL order_wdata: got %h expected deadbeef", s_wdata);
    end
    do_accept(1, 1'b1);
    do_accept(0, 1'b0);
    drain(3, 32'hA);
  endtask

  task automatic test_simultaneous();
    do_accept(0, 1'b0);
    do_accept(1, 1'b0);
    m_req = 2'b01;
    s_addr_ok = 1'b1;
    s_data_ok = 1'b1;
    s_rdata = 32'h1234;
    #2;
    checks++;
    if (m_addr_ok !== 2'b01 || m_data_ok !== 2'b01) begin
      errors++;
      $display("FAIL simul_both: got addr_ok %b data_ok %b expected 01 01", m_addr_ok, m_data_ok);
    end
    void'(exp_q.pop_front());
    exp_q.push_back(0);
    step();
    checks++;
    if (outstanding !== 3'd2) begin
      errors++;
      $display("FAIL simul_count: got %0d expected 2", outstanding);
    end
    m_req = '0;
    s_addr_ok = 1'b0;
    s_data_ok = 1'b0;
    do_accept(1, 1'b0);
    do_accept(1, 1'b0);
    m_req = 2'b01;
    s_addr_ok = 1'b1;
    s_data_ok = 1'b1;
    s_rdata = 32'h5678;
    #2;
    checks++;
    if (s_req !== 1'b0 || m_addr_ok !== 2'b00 || m_data_ok !== 2'b10) begin
      errors++;
      $display("FAIL full_pop: got s_req %b addr_ok %b data_ok %b expected 0 00 10", s_req, m_addr_ok, m_data_ok);
    end
    void'(exp_q.pop_front());
    cnt--;
    step();
    s_data_ok = 1'b0;
    #2;
    checks++;
    if (outstanding !== 3'd3 || m_addr_ok !== 2'b01) begin
      errors++;
      $display("FAIL full_resume: got out %0d addr_ok %b expected 3 01", outstanding, m_addr_ok);
    end
    exp_q.push_back(0);
    cnt++;
    step();
    m_req = '0;
    s_addr_ok = 1'b0;
    drain(4, 32'h90);
  endtask

  task automatic test_proto_err();
    s_data_ok = 1'b1;
    #2;
    checks++;
    if (m_data_ok !== 2'b00) begin
      errors++;
      $display("FAIL perr_data_ok: got %b expected 00", m_data_ok);
    end
    step();
    s_data_ok = 1'b0;
    step();
    checks++;
    if (proto_err !== 1'b1 || outstanding !== 3'd0) begin
      errors++;
      $display("FAIL perr_sticky: got perr %b out %0d expected 1 0", proto_err, outstanding);
    end
  endtask

  task automatic test_async_reset();
    do_accept(0, 1'b0);
    do_accept(0, 1'b0);
    do_accept(0, 1'b0);
    checks++;
    if (outstanding !== 3'd3) begin
      errors++;
      $display("FAIL areset_pre: got %0d expected 3", outstanding);
    end
    m_req = 2'b01;
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (outstanding !== 3'd0 || proto_err !== 1'b0 || s_req !== 1'b0 || m_addr_ok !== 2'b00) begin
      errors++;
      $display("FAIL areset_now: got out %0d perr %b s_req %b addr_ok %b expected 0 0 0 00", outstanding, proto_err, s_req, m_addr_ok);
    end
    exp_q.delete();
    cnt = 0;
    step();
    m_req = '0;
    resetn = 1'b1;
    s_data_ok = 1'b1;
    #2;
    checks++;
    if (m_data_ok !== 2'b00) begin
      errors++;
      $display("FAIL areset_discard: got %b expected 00", m_data_ok);
    end
    step();
    s_data_ok = 1'b0;
  endtask

  task automatic test_round_robin();
    r_addr = {32'h0000_1020, 32'h0000_1010, 32'h0000_1000};
    r_req = 3'b111;
    r_s_addr_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #2;
      checks++;
      if (r_addr_ok !== 3'b001 << (i % 3) || r_s_addr !== 32'h1000 + 32'((i % 3) * 16)) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b/%h expected %b/%h", i, r_addr_ok, r_s_addr, 3'b001 << (i % 3), 32'h1000 + 32'((i % 3) * 16));
      end
      step();
    end
    r_req = '0;
    r_s_addr_ok = 1'b0;
    checks++;
    if (r_out !== 4'd6) begin
      errors++;
      $display("FAIL rr_outstanding: got %0d expected 6", r_out);
    end
  endtask

  initial begin
    resetn = 1'b0;
    m_req = '0; m_wr = '0; m_size = 4'b1010; m_addr = '0; m_wdata = '0;
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
    r_req = '0; r_wr = '0; r_size = '0; r_addr = '0; r_wdata = '0;
    r_s_addr_ok = 1'b0; r_s_data_ok = 1'b0; r_s_rdata = '0;
    #12;
    test_reset();
    test_fill();
    test_lock();
    test_ordering();
    test_simultaneous();
    test_proto_err();
    test_async_reset();
    test_round_robin();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
